// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer for the 16-bit CPU: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, owns the memory wait timeout, and counts retired instructions.
//
//   state  | meaning
//   IDLE   | out of reset, waiting for run
//   FETCH  | instruction read from PC address
//   DECODE | opcode latched and classified
//   EXEC   | ALU op; branches/jumps resolve here
//   MEM    | data read (lw) or write (sw)
//   WB     | register file write-back
//   HALT   | stopped (halt, illegal opcode or bus error); run resumes
module multicycle_control #(
    parameter int OP_W     = 4,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_is_data,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic             reg_write,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] OP_ATYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1011;
    localparam logic [3:0] OP_BLT   = 4'b0100;
    localparam logic [3:0] OP_BGT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [3:0]       op_lo;
    logic             op_hi_zero;
    logic             op_legal;
    logic [7:0]       wait_cnt;
    logic             mem_wait;
    logic             timeout;
    logic             br_taken;
    logic             retire;
    logic             set_illegal, set_bus_err, clear_flags;
    logic             illegal_q, bus_err_q;
    logic [CNT_W-1:0] retired_q;

    assign op_lo      = opcode[3:0];
    assign op_hi_zero = (opcode >> 4) == '0;

    always_comb begin
        op_legal = 1'b0;
        if (op_hi_zero) begin
            case (op_lo)
                OP_ATYPE, OP_LW, OP_SW, OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT: op_legal = 1'b1;
                default: op_legal = 1'b0;
            endcase
        end
    end

    // Down-counter reloads whenever no wait is in progress; hitting zero while
    // still waiting is the WAIT_MAX-th cycle without mem_ready.
    assign mem_wait = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign timeout  = mem_wait && (wait_cnt == 8'd0);

    always_comb begin
        case (op_q)
            OP_BLT:  br_taken = alu_neg;
            OP_BGT:  br_taken = !alu_neg && !alu_zero;
            OP_BEQ:  br_taken = alu_zero;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_is_data = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        alu_op      = 2'b00;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        clear_flags = 1'b0;
        case (state)
            S_IDLE: if (run) state_nxt = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_nxt   = S_HALT;
                end
            end
            S_DECODE: begin
                if (!op_legal) begin
                    set_illegal = 1'b1;
                    state_nxt   = S_HALT;
                end else if (op_lo == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ATYPE: state_nxt = S_WB;
                    OP_LW, OP_SW: begin
                        alu_op    = 2'b10;
                        alu_src   = 1'b1;
                        state_nxt = S_MEM;
                    end
                    OP_BLT, OP_BGT, OP_BEQ: begin
                        alu_op    = 2'b01;
                        pc_write  = br_taken;
                        pc_src    = br_taken ? 2'b01 : 2'b00;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_MEM: begin
                mem_is_data = 1'b1;
                mem_read    = (op_q == OP_LW);
                mem_write   = (op_q == OP_SW);
                if (mem_ready) begin
                    retire    = (op_q == OP_SW);
                    state_nxt = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_nxt   = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_ATYPE);
                mem_to_reg = (op_q != OP_ATYPE);
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_HALT: begin
                if (run) begin
                    clear_flags = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= 4'b0000;
            wait_cnt  <= WAIT_LOAD;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (mem_wait && !timeout) ? wait_cnt - 8'd1 : WAIT_LOAD;
            if (state == S_DECODE) op_q <= op_lo;
            if (clear_flags) begin
                illegal_q <= 1'b0;
                bus_err_q <= 1'b0;
            end else begin
                if (set_illegal) illegal_q <= 1'b1;
                if (set_bus_err) bus_err_q <= 1'b1;
            end
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign halted  = (state == S_HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-accurate scoreboard bench for multicycle_control; a second instance with a
// 2-bit retired counter runs the same stimulus to exercise counter wrap.
module tb_multicycle_control;
    localparam logic [3:0] OP_A = 4'b0000, OP_LW = 4'b1000, OP_SW = 4'b1011, OP_BLT = 4'b0100,
                           OP_BGT = 4'b0101, OP_BEQ = 4'b0110, OP_JMP = 4'b1100, OP_HLT = 4'b1111;
    localparam logic [15:0] IRW = 16'h8000, PCW = 16'h4000, SRC_J = 16'h2000, SRC_BR = 16'h1000,
                            MRD = 16'h0800, MWR = 16'h0400, MDAT = 16'h0200, RDST = 16'h0100,
                            M2R = 16'h0080, ASRC = 16'h0040, RWR = 16'h0020, AOP_ADD = 16'h0010,
                            AOP_SUB = 16'h0008, HLT = 16'h0004, ILL = 16'h0002, BERR = 16'h0001;

    logic clk = 1'b0;
    logic rst, run, mem_ready, alu_zero, alu_neg;
    logic [3:0] opcode;
    logic ir_write, pc_write, mem_read, mem_write, mem_is_data, reg_dst, mem_to_reg, alu_src, reg_write;
    logic halted, illegal, bus_err;
    logic [1:0] pc_src, alu_op;
    logic [15:0] ret1;
    logic ir_write2, pc_write2, mem_read2, mem_write2, mem_is_data2, reg_dst2, mem_to_reg2, alu_src2, reg_write2;
    logic halted2, illegal2, bus_err2;
    logic [1:0] pc_src2, alu_op2, ret2;
    logic [15:0] obs, obs2;

    multicycle_control dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write), .mem_is_data(mem_is_data),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_write(reg_write),
        .alu_op(alu_op), .halted(halted), .illegal(illegal), .bus_err(bus_err), .retired(ret1)
    );

    multicycle_control #(.OP_W(4), .CNT_W(2), .WAIT_MAX(15)) dut2 (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .ir_write(ir_write2), .pc_write(pc_write2),
        .pc_src(pc_src2), .mem_read(mem_read2), .mem_write(mem_write2), .mem_is_data(mem_is_data2),
        .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .alu_src(alu_src2), .reg_write(reg_write2),
        .alu_op(alu_op2), .halted(halted2), .illegal(illegal2), .bus_err(bus_err2), .retired(ret2)
    );

    assign obs  = {ir_write, pc_write, pc_src, mem_read, mem_write, mem_is_data, reg_dst,
                   mem_to_reg, alu_src, reg_write, alu_op, halted, illegal, bus_err};
    assign obs2 = {ir_write2, pc_write2, pc_src2, mem_read2, mem_write2, mem_is_data2, reg_dst2,
                   mem_to_reg2, alu_src2, reg_write2, alu_op2, halted2, illegal2, bus_err2};

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] tag;
        logic        rst, run, rdy, z, n;
        logic [3:0]  op;
        logic [15:0] exp;
        logic [15:0] ret;
    } cyc_t;

    cyc_t        sb[$];
    cyc_t        c;
    logic [15:0] model_ret;
    logic        run_bg;
    int          checks = 0;
    int          errors = 0;

    task automatic add(input logic [63:0] tag, input logic r, input logic rn, input logic rdy,
                       input logic z, input logic n, input logic [3:0] op, input logic [15:0] exp,
                       input logic ret_now);
        cyc_t e;
        e.tag = tag; e.rst = r; e.run = rn; e.rdy = rdy; e.z = z; e.n = n; e.op = op;
        e.exp = exp; e.ret = model_ret;
        sb.push_back(e);
        if (r) model_ret = 16'd0;
        else if (ret_now) model_ret = model_ret + 16'd1;
    endtask

    // Expected cycle sequence of one instruction starting in FETCH.
    task automatic inst(input logic [3:0] op, input int wf, input int wm, input logic z, input logic n);
        for (int i = 0; i < wf; i++) add("fwait", 0, run_bg, 0, z, n, op, MRD, 0);
        add("fetch", 0, run_bg, 1, z, n, op, IRW | PCW | MRD, 0);
        add("decode", 0, run_bg, 1, z, n, op, 16'h0, 0);
        case (op)
            OP_A: begin
                add("exec", 0, run_bg, 1, z, n, op, 16'h0, 0);
                add("wb", 0, run_bg, 1, z, n, op, RWR | RDST, 1);
            end
            OP_LW, OP_SW: begin
                add("exec", 0, run_bg, 1, z, n, op, AOP_ADD | ASRC, 0);
                for (int i = 0; i < wm; i++)
                    add("mwait", 0, run_bg, 0, z, n, op, MDAT | ((op == OP_LW) ? MRD : MWR), 0);
                add("mem", 0, run_bg, 1, z, n, op, MDAT | ((op == OP_LW) ? MRD : MWR), op == OP_SW);
                if (op == OP_LW) add("wb", 0, run_bg, 1, z, n, op, RWR | M2R, 1);
            end
            OP_BLT: add("exec", 0, run_bg, 1, z, n, op, AOP_SUB | (n ? (PCW | SRC_BR) : 16'h0), 1);
            OP_BGT: add("exec", 0, run_bg, 1, z, n, op, AOP_SUB | ((!n && !z) ? (PCW | SRC_BR) : 16'h0), 1);
            OP_BEQ: add("exec", 0, run_bg, 1, z, n, op, AOP_SUB | (z ? (PCW | SRC_BR) : 16'h0), 1);
            OP_JMP: add("exec", 0, run_bg, 1, z, n, op, PCW | SRC_J, 1);
            default: ;
        endcase
    endtask

    task automatic drive(input cyc_t e);
        @(posedge clk); #1;
        rst = e.rst; run = e.run; mem_ready = e.rdy; alu_zero = e.z; alu_neg = e.n; opcode = e.op;
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_ret = 16'd0;
        run_bg = 1'b0;
        add("idle", 0, 0, 0, 0, 0, OP_A, 16'h0, 0);
        add("idle", 0, 0, 1, 0, 0, OP_JMP, 16'h0, 0);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL reset %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_atype();
        add("run", 0, 1, 1, 0, 0, OP_A, 16'h0, 0);
        inst(OP_A, 0, 0, 0, 0);
        inst(OP_A, 0, 0, 1, 1);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL atype %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_mem_ops();
        inst(OP_LW, 0, 3, 0, 0);
        inst(OP_SW, 2, 0, 0, 0);
        inst(OP_SW, 0, 1, 0, 0);
        inst(OP_LW, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL memops %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_branches();
        run_bg = 1'b1;
        inst(OP_BEQ, 0, 0, 1, 0);
        inst(OP_BGT, 0, 0, 0, 1);
        inst(OP_BLT, 0, 0, 0, 1);
        inst(OP_BLT, 0, 0, 1, 0);
        inst(OP_BGT, 0, 0, 0, 0);
        inst(OP_BEQ, 0, 0, 0, 1);
        inst(OP_JMP, 0, 0, 0, 0);
        run_bg = 1'b0;
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL branch %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_wait_boundary();
        inst(OP_A, 14, 0, 0, 0);
        inst(OP_LW, 0, 14, 0, 0);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL waitmax %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 15; i++) add("fwait", 0, 0, 0, 0, 0, OP_A, MRD, 0);
        add("halt", 0, 0, 0, 0, 0, OP_A, HLT | BERR, 0);
        add("halt", 0, 0, 1, 0, 0, OP_A, HLT | BERR, 0);
        add("resume", 0, 1, 1, 0, 0, OP_A, HLT | BERR, 0);
        inst(OP_JMP, 0, 0, 0, 0);
        add("fetch", 0, 0, 1, 0, 0, OP_SW, IRW | PCW | MRD, 0);
        add("decode", 0, 0, 1, 0, 0, OP_SW, 16'h0, 0);
        add("exec", 0, 0, 1, 0, 0, OP_SW, AOP_ADD | ASRC, 0);
        for (int i = 0; i < 15; i++) add("mwait", 0, 0, 0, 0, 0, OP_SW, MDAT | MWR, 0);
        add("halt", 0, 0, 0, 0, 0, OP_SW, HLT | BERR, 0);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL timeout %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] bad [3];
        bad[0] = 4'b1010; bad[1] = 4'b0001; bad[2] = 4'b1101;
        add("resume", 0, 1, 1, 0, 0, OP_A, HLT | BERR, 0);
        for (int i = 0; i < 3; i++) begin
            inst(bad[i], 0, 0, 0, 0);
            add("halt", 0, 0, 1, 0, 0, bad[i], HLT | ILL, 0);
            add("resume", 0, 1, 1, 0, 0, bad[i], HLT | ILL, 0);
        end
        inst(OP_HLT, 0, 0, 0, 0);
        add("halt", 0, 0, 1, 0, 0, OP_HLT, HLT, 0);
        add("resume", 0, 1, 1, 0, 0, OP_HLT, HLT, 0);
        inst(OP_A, 0, 0, 0, 0);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL illegal %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_reset_mid();
        add("fetch", 0, 0, 1, 0, 0, OP_SW, IRW | PCW | MRD, 0);
        add("decode", 0, 0, 1, 0, 0, OP_SW, 16'h0, 0);
        add("exec", 0, 0, 1, 0, 0, OP_SW, AOP_ADD | ASRC, 0);
        add("mem_rst", 1, 0, 0, 0, 0, OP_SW, MDAT | MWR, 0);
        add("idle", 0, 0, 1, 0, 0, OP_SW, 16'h0, 0);
        add("idle", 0, 0, 1, 0, 0, OP_SW, 16'h0, 0);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL rstmid %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    task automatic test_wrap();
        add("run", 0, 1, 1, 0, 0, OP_JMP, 16'h0, 0);
        for (int i = 0; i < 5; i++) inst(OP_JMP, 0, 0, 0, 0);
        inst(OP_HLT, 0, 0, 0, 0);
        add("halt", 0, 0, 1, 0, 0, OP_HLT, HLT, 0);
        while (sb.size() != 0) begin
            c = sb.pop_front();
            drive(c);
            checks++;
            if ({obs, obs2, ret1, ret2} !== {c.exp, c.exp, c.ret, c.ret[1:0]}) begin
                errors++;
                $display("FAIL wrap %s: out %h/%h ret %0d/%0d, required out %h ret %0d", c.tag, obs, obs2, ret1, ret2, c.exp, c.ret);
            end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; opcode = 4'b0000;
        model_ret = 16'd0;
        run_bg = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_atype();
        test_mem_ops();
        test_branches();
        test_wait_boundary();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
